// File: rtl/id_hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending-write scoreboard for RAW/WAW
// hazards, a multi-cycle flush window after redirects, and a saturating stall counter.
module id_hazard_scoreboard #(
    parameter int PEND_W       = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_BYPASS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_regwrite,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic        wb_regwrite,
    input  logic        redirect,
    output logic        stall,
    output logic        issue,
    output logic        flush,
    output logic [31:0] busy_vec,
    output logic [15:0] stall_cycles
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic              BYPASS   = (WB_BYPASS != 0);
    localparam int                CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PEND_W-1:0] pend [32];
    logic [31:0]       inc_vec, dec_vec;
    logic              rs_hit, rt_hit, waw_hit, hazard, flush_i;

    // Register 0 is never tracked, so bit 0 of both vectors stays low.
    always_comb begin
        dec_vec = '0;
        for (int i = 1; i < 32; i++) begin
            dec_vec[i] = wb_valid & wb_regwrite & (wb_dest == 5'(i));
        end
    end

    always_comb begin
        inc_vec = '0;
        for (int i = 1; i < 32; i++) begin
            inc_vec[i] = issue & id_regwrite & (id_dest == 5'(i));
        end
    end

    // With a write-through register file, retiring the last pending write unblocks readers now.
    always_comb begin
        rs_hit  = id_uses_rs && (id_rs != 5'd0) && (pend[id_rs] != '0)
                  && !(BYPASS && (pend[id_rs] == PEND_ONE) && dec_vec[id_rs]);
        rt_hit  = id_uses_rt && (id_rt != 5'd0) && (pend[id_rt] != '0)
                  && !(BYPASS && (pend[id_rt] == PEND_ONE) && dec_vec[id_rt]);
        waw_hit = id_regwrite && (id_dest != 5'd0) && (pend[id_dest] == PEND_MAX)
                  && !dec_vec[id_dest];
        hazard  = rs_hit | rt_hit | waw_hit;
    end

    always_comb begin
        flush_i = rst_n & (redirect | (state == FLUSH));
        flush   = flush_i;
        stall   = rst_n & id_valid & ~flush_i & hazard;
        issue   = rst_n & id_valid & ~flush_i & ~hazard;
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = (pend[i] != '0);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (redirect && (FLUSH_CYCLES > 1)) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_RELOAD;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    cnt_next = CNT_RELOAD;
                end else if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Simultaneous inc and dec cancel; a dec on an empty counter is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i] && (pend[i] != PEND_MAX)) begin
                    pend[i] <= pend[i] + PEND_ONE;
                end else if (dec_vec[i] && !inc_vec[i] && (pend[i] != '0)) begin
                    pend[i] <= pend[i] - PEND_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed scenarios plus random traffic, all checked
// against an in-bench model built on integer pending counts and a flush-cycles-left count.
module tb_id_hazard_scoreboard;

    localparam int PEND_W   = 2;
    localparam int FC       = 2;
    localparam int BYP      = 1;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic [4:0]  id_dest = '0;
    logic        id_regwrite = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic        wb_regwrite = 1'b0;
    logic        redirect = 1'b0;
    logic        stall, issue, flush;
    logic [31:0] busy_vec;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    int pend_m [32];
    int sc_m       = 0;
    int flush_left = 0;

    id_hazard_scoreboard #(.PEND_W(PEND_W), .FLUSH_CYCLES(FC), .WB_BYPASS(BYP)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
        .redirect(redirect),
        .stall(stall), .issue(issue), .flush(flush),
        .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (pend_m[r] > 0);
        return b;
    endfunction

    // One clock cycle: apply inputs after the falling edge, check, then advance the model.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic wv, input logic [4:0] wd,
                         input logic wr, input logic rd, input string tag);
        int  wb_rs, wb_rt, wb_dst, eff_rs, eff_rt;
        logic hz, fl, e_stall, e_issue;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dst; id_regwrite = rw; wb_valid = wv; wb_dest = wd; wb_regwrite = wr;
        redirect = rd;
        #1;
        wb_rs  = (wv && wr && wd == rs)  ? 1 : 0;
        wb_rt  = (wv && wr && wd == rt)  ? 1 : 0;
        wb_dst = (wv && wr && wd == dst) ? 1 : 0;
        eff_rs = pend_m[rs] - BYP * wb_rs;
        eff_rt = pend_m[rt] - BYP * wb_rt;
        hz = (urs && rs != 0 && eff_rs > 0) || (urt && rt != 0 && eff_rt > 0)
             || (rw && dst != 0 && (pend_m[dst] - wb_dst) >= PEND_MAX);
        fl      = rd || (flush_left > 0);
        e_stall = v && !fl && hz;
        e_issue = v && !fl && !hz;
        check_eq({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check_eq({tag, ".issue"}, 32'(issue), 32'(e_issue));
        check_eq({tag, ".flush"}, 32'(flush), 32'(fl));
        check_eq({tag, ".busy"}, busy_vec, model_busy());
        check_eq({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(sc_m));
        if (e_issue && rw && dst != 0) pend_m[dst]++;
        if (wv && wr && wd != 0 && pend_m[wd] > 0) pend_m[wd]--;
        if (e_stall && sc_m < 65535) sc_m++;
        if (rd) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic wb(input logic [4:0] r, input string tag);
        drive(0, 0, 0, 0, 0, 0, 0, 1, r, 1, 0, tag);
    endtask

    // Hold reset with busy inputs; every output must read zero.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; id_valid = 1'b1; redirect = 1'b1; id_regwrite = 1'b1; id_dest = 5'd4;
        id_uses_rs = 1'b1; id_rs = 5'd4; wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq({tag, ".stall"}, 32'(stall), 32'd0);
            check_eq({tag, ".issue"}, 32'(issue), 32'd0);
            check_eq({tag, ".flush"}, 32'(flush), 32'd0);
            check_eq({tag, ".busy"}, busy_vec, 32'd0);
            check_eq({tag, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
            @(negedge clk);
        end
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        sc_m = 0;
        flush_left = 0;
        id_valid = 1'b0; redirect = 1'b0; id_regwrite = 1'b0; id_uses_rs = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        do_reset("reset");

        // RAW on r3, released by a same-cycle writeback
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, "raw_wr");
        for (int i = 0; i < 3; i++) drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, "raw_stall");
        drive(1, 3, 0, 1, 0, 4, 1, 1, 3, 1, 0, "raw_bypass");
        wb(4, "raw_after");
        idle("raw_idle");

        // register 0 is never tracked
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "r0_wr");
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, "r0_rd");
        wb(0, "r0_wb");

        // WAW saturation on r5
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, "waw_fill");
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, "waw_block");
        drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 1, 0, "waw_release");
        for (int i = 0; i < 3; i++) wb(5, "waw_drain");
        idle("waw_idle");

        // flush window, then a redirect inside it
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 1, "fl_t0");
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 0, "fl_t1");
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 0, "fl_t2");
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 1, "fl2_t0");
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 1, "fl2_t1");
        drive(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 0, "fl2_t2");
        drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, "fl2_t3");
        for (int i = 0; i < 2; i++) wb(6, "fl_drain");

        // simultaneous inc/dec on r7
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, "incdec_a");
        drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 1, 0, "incdec_b");
        drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, "incdec_c");
        wb(7, "incdec_d");
        wb(7, "underflow");
        idle("incdec_idle");

        // random traffic over a small register window
        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) < 4),
                  5'($urandom_range(0, 7)), logic'($urandom_range(0, 7) != 0),
                  logic'($urandom_range(0, 9) == 0), "rand");
        end

        do_reset("mid_reset");
        idle("post_reset");

        // long stall to saturate the counter
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, "sat_wr");
        for (int i = 0; i < 70000; i++) drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, "sat");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_end");
        check_eq("sat_final", 32'(stall_cycles), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Issue controller for the decode stage of the 5-stage RISC pipeline.
- Tracks in-flight register-file writes using a per-register pending counter (scoreboard).
- Stalls the decode-stage instruction while any of its source registers has a pending write.
- Drives a multi-cycle flush window after a control-flow redirect (beq/bne taken, jump) and counts stall cycles for performance analysis.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W-1.
- FLUSH_CYCLES, 2, number of consecutive cycles flush stays high per redirect (≥1).
- WB_BYPASS, 1, 1 = a same-cycle writeback that retires the last pending write clears the hazard combinationally (register file is write-through); 0 = hazard clears the cycle after.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs  in  5  source register 1 (instruction[25:21]).
- id_rt  in  5  source register 2 (instruction[20:16]).
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_dest  in  5  destination register (Rd or Rt per RegDst).
- id_regwrite  in  1  instruction writes the register file.
- wb_valid  in  1  writeback stage valid.
- wb_dest  in  5  writeback destination register.
- wb_regwrite  in  1  writeback writes the register file.
- redirect  in  1  taken branch or jump resolved this cycle.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- issue  out  1  decode instruction advances to EX this cycle.
- flush  out  1  squash IF/ID contents.
- busy_vec  out  32  bit i = pending counter of register i nonzero.
- stall_cycles  out  16  saturating count of cycles with stall=1.

Behaviour:
- Reset (async, rst_n=0):
  - all pending counters, stall_cycles and the flush counter clear to 0; state = IDLE.
  - Outputs: stall=0, issue=0, flush=0, busy_vec=0.
- Register 0:
  - never tracked; its counter stays 0 and busy_vec[0]=0 always.
  - issue or writeback targeting register 0 has no effect.
- Hazard, combinational:
  - src_hit(r) = uses & r≠0 & pend[r]≠0.
  - If WB_BYPASS=1, a register with pend[r]==1 and a same-cycle writeback to r is treated as not pending.
  - WAW guard: hazard also asserted when id_regwrite & id_dest≠0 & pend[id_dest] is at max.
- Outputs, combinational:
  - flush = redirect | (state==FLUSH).
  - stall = id_valid & ~flush & hazard.
  - issue = id_valid & ~flush & ~hazard.
- Scoreboard update on the clock edge, per register r:
  - inc = issue & id_regwrite & id_dest==r.
  - dec = wb_valid & wb_regwrite & wb_dest==r.
  - inc & dec: counter unchanged. inc only: +1. dec only: -1.
  - dec with counter 0 is a protocol error: counter holds at 0 (no underflow).
- Flush FSM, states IDLE and FLUSH; cnt holds the remaining flush cycles:
  - IDLE: redirect & FLUSH_CYCLES>1 → FLUSH with cnt = FLUSH_CYCLES-1.
  - FLUSH: cnt decrements each cycle; → IDLE when cnt reaches 1 and there is no redirect.
  - redirect while in FLUSH reloads cnt = FLUSH_CYCLES-1 (window restarts).
  - FLUSH_CYCLES=1: flush = redirect only; the FSM never leaves IDLE.
- Flush vs. stall: flush overrides stall. A squashed instruction never increments the scoreboard; in-flight writebacks still decrement.
- stall_cycles increments by 1 each cycle stall=1 and saturates at 16'hFFFF.
- Reset asserted mid-operation discards all pending state; the environment must also flush the pipeline.

Test Plan:
1. Reset
   - Stimulus: rst_n=0 with id_valid=1, redirect=1.
   - Required: stall=0, issue=0, flush=0, busy_vec=0, stall_cycles=0 while reset is held.
2. RAW stall (WB_BYPASS=1)
   - Stimulus: issue a write to r3; next cycle decode reads rs=3.
   - Required: stall=1 and issue=0 until wb_dest=3 arrives. In the writeback cycle stall=0 and issue=1; busy_vec[3] returns to 0 after that edge.
3. Register 0 ignored
   - Stimulus: issue write to r0, then decode reads rs=0.
   - Required: busy_vec[0]=0, no stall.
4. WAW saturation (PEND_W=2)
   - Stimulus: issue 3 writes to r5 with no writeback, then a 4th write to r5.
   - Required: 4th is stalled; one wb to r5 unblocks it the same cycle; pend[r5] stays 3.
5. Flush window (FLUSH_CYCLES=2)
   - Stimulus: redirect at cycle T with a hazard-free id_valid=1.
   - Required: flush=1 at T and T+1, issue=0 at both, no scoreboard increment. Redirect again at T+1 extends flush through T+2.
6. Simultaneous inc/dec and counter saturation
   - Stimulus: issue to r7 and wb to r7 in the same cycle with pend[r7]=1.
   - Required: pend[r7] stays 1.
   - Stimulus: hold a stall for 70000 cycles.
   - Required: stall_cycles=16'hFFFF.
